// File: rtl/product_nibble_serializer_if.sv
// Product-in / nibble-out handshake bundle.
// slave = serializer side, master = producer/consumer side.
interface product_nibble_serializer_if;
  logic [7:0] in_product;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_sel;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_product,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_sel,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_product,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_sel,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/product_nibble_serializer.sv
// Splits an 8-bit product into low/high nibble beats.
// Optional macro ZERO_HI_SKIP_EN: send zero-high products as one beat.
module product_nibble_serializer #(
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  product_nibble_serializer_if.slave bus,
  output logic [CNT_W-1:0]           prod_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     state_n;
  logic [7:0] prod;
  logic       hi_zero;
  logic       done;

`ifdef ZERO_HI_SKIP_EN
  assign hi_zero = (prod[7:4] == 4'h0);
`else
  assign hi_zero = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state and beat outputs, all decoded from registered state
  always_comb begin
    state_n       = state;
    done          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 4'h0;
    bus.out_sel   = 1'b0;
    bus.out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = LO;
      end
      LO: begin
        bus.out_valid = 1'b1;
        bus.out_data  = prod[3:0];
        bus.out_last  = hi_zero;
        if (bus.out_ready) begin
          state_n = hi_zero ? IDLE : HI;
          done    = hi_zero;
        end
      end
      HI: begin
        bus.out_valid = 1'b1;
        bus.out_data  = prod[7:4];
        bus.out_sel   = 1'b1;
        bus.out_last  = 1'b1;
        if (bus.out_ready) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // capture the product only while idle
  always_ff @(posedge clk) begin
    if (rst)
      prod <= 8'h00;
    else if (state == IDLE && bus.in_valid)
      prod <= bus.in_product;
  end

  // saturating count of completed products
  always_ff @(posedge clk) begin
    if (rst)
      prod_cnt <= '0;
    else if (done && prod_cnt != CNT_MAX)
      prod_cnt <= prod_cnt + 1'b1;
  end

endmodule
